// File: rtl/tdiv_rest_param.sv
// Restoring divider, WIDTH-bit, signed or unsigned per operation.
// RISC-V M semantics for divide-by-zero and signed overflow.
module tdiv_rest_param #(
  parameter int WIDTH = 32,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rstLow,
  input  logic             start_in,
  input  logic             signed_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] q_out,
  output logic [WIDTH-1:0] r_out,
  output logic             busy,
  output logic             done,
  output logic             div0
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PREP = 2'd1;
  localparam logic [1:0] S_LOOP = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] r_a;
  logic             r_sgn;
  logic             r_sa;
  logic             r_sb;
  logic             r_b0;

  logic [WIDTH:0]   w_res;
  logic             w_neg;
  logic             w_b0;
  logic             w_last;
  logic [WIDTH-1:0] w_absa;
  logic [WIDTH-1:0] w_absb;

  // r_a and r_div hold the raw operands from the start cycle until PREP
  assign w_absa = (r_sgn & r_a[WIDTH-1]) ? -r_a : r_a;
  assign w_absb = (r_sgn & r_div[WIDTH-1]) ? -r_div : r_div;
  assign w_b0   = (r_div == '0);
  assign w_res  = {r_rem, r_q[WIDTH-1]} - {1'b0, r_div};
  assign w_neg  = w_res[WIDTH];
  assign w_last = (r_cnt == CW'(WIDTH - 1));
  assign busy   = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge rstLow) begin
    if (!rstLow) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_q     <= '0;
      r_rem   <= '0;
      r_div   <= '0;
      r_a     <= '0;
      r_sgn   <= 1'b0;
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
      r_b0    <= 1'b0;
      q_out   <= '0;
      r_out   <= '0;
      done    <= 1'b0;
      div0    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start_in) begin
            r_a     <= a_in;
            r_div   <= b_in;
            r_sgn   <= signed_in;
            r_state <= S_PREP;
          end
        end
        S_PREP: begin
          r_sa    <= r_sgn & r_a[WIDTH-1];
          r_sb    <= r_sgn & r_div[WIDTH-1];
          r_b0    <= w_b0;
          r_q     <= w_absa;
          r_div   <= w_absb;
          r_rem   <= '0;
          r_cnt   <= '0;
          r_state <= w_b0 ? S_FIX : S_LOOP;
        end
        S_LOOP: begin
          if (!w_neg) begin
            r_rem <= w_res[WIDTH-1:0];
            r_q   <= {r_q[WIDTH-2:0], 1'b1};
          end else begin
            r_rem <= {r_rem[WIDTH-2:0], r_q[WIDTH-1]};
            r_q   <= {r_q[WIDTH-2:0], 1'b0};
          end
          r_cnt <= r_cnt + CW'(1);
          if (w_last) r_state <= S_FIX;
        end
        S_FIX: begin
          if (r_b0) begin
            q_out <= '1;
            r_out <= r_a;
            div0  <= 1'b1;
          end else begin
            q_out <= (r_sa ^ r_sb) ? -r_q : r_q;
            r_out <= r_sa ? -r_rem : r_rem;
            div0  <= 1'b0;
          end
          done    <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tdiv_rest_param.sv
// Scoreboard bench for tdiv_rest_param: 32-bit and 8-bit instances.
// Expected results are queued at issue and checked on each done pulse.
module tb_tdiv_rest_param;

  typedef struct {
    logic [63:0] q;
    logic [63:0] r;
    logic        d0;
    int          lat;
  } exp_t;

  logic        clk;
  logic        rstLow;

  logic        st32, sg32;
  logic [31:0] a32, b32, q32, r32;
  logic        busy32, done32, div032;

  logic        st8, sg8;
  logic [7:0]  a8, b8, q8, r8;
  logic        busy8, done8, div08;

  int n_chk;
  int n_fail;
  int bc32;
  int bc8;
  exp_t sb32[$];
  exp_t sb8[$];
  exp_t e32;
  exp_t e8;

  tdiv_rest_param #(.WIDTH(32)) dut32 (
    .clk(clk), .rstLow(rstLow), .start_in(st32), .signed_in(sg32),
    .a_in(a32), .b_in(b32), .q_out(q32), .r_out(r32),
    .busy(busy32), .done(done32), .div0(div032)
  );

  tdiv_rest_param #(.WIDTH(8)) dut8 (
    .clk(clk), .rstLow(rstLow), .start_in(st8), .signed_in(sg8),
    .a_in(a8), .b_in(b8), .q_out(q8), .r_out(r8),
    .busy(busy8), .done(done8), .div0(div08)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rstLow) begin
      bc32 = 0;
    end else begin
      if (busy32) bc32++;
      if (done32) begin
        if (sb32.size() == 0) begin
          chk("w32 extra done", 64'(sb32.size()), 64'd1);
        end else begin
          e32 = sb32.pop_front();
          chk("w32 q", 64'(q32), e32.q);
          chk("w32 r", 64'(r32), e32.r);
          chk("w32 div0", 64'(div032), 64'(e32.d0));
          chk("w32 busy cycles", 64'(bc32), 64'(e32.lat));
        end
        bc32 = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rstLow) begin
      bc8 = 0;
    end else begin
      if (busy8) bc8++;
      if (done8) begin
        if (sb8.size() == 0) begin
          chk("w8 extra done", 64'(sb8.size()), 64'd1);
        end else begin
          e8 = sb8.pop_front();
          chk("w8 q", 64'(q8), e8.q);
          chk("w8 r", 64'(r8), e8.r);
          chk("w8 div0", 64'(div08), 64'(e8.d0));
          chk("w8 busy cycles", 64'(bc8), 64'(e8.lat));
        end
        bc8 = 0;
      end
    end
  end

  task automatic wait32();
    logic got;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done32) begin
        got = 1'b1;
        break;
      end
    end
    chk("w32 done seen", 64'(got), 64'd1);
  endtask

  task automatic wait8();
    logic got;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done8) begin
        got = 1'b1;
        break;
      end
    end
    chk("w8 done seen", 64'(got), 64'd1);
  endtask

  // Caller is at a negedge with the 32-bit unit idle or on its done cycle
  task automatic op32(input logic s, input logic [31:0] a, b,
                      input logic [31:0] eq, er, input logic ed);
    exp_t e;
    e.q = 64'(eq);
    e.r = 64'(er);
    e.d0 = ed;
    e.lat = ed ? 2 : 34;
    sb32.push_back(e);
    st32 = 1'b1; sg32 = s; a32 = a; b32 = b;
    @(negedge clk);
    st32 = 1'b0; sg32 = ~s; a32 = ~a; b32 = ~b;
    wait32();
  endtask

  task automatic op8(input logic s, input logic [7:0] a, b,
                     input logic [7:0] eq, er, input logic ed);
    exp_t e;
    e.q = 64'(eq);
    e.r = 64'(er);
    e.d0 = ed;
    e.lat = ed ? 2 : 10;
    sb8.push_back(e);
    st8 = 1'b1; sg8 = s; a8 = a; b8 = b;
    @(negedge clk);
    st8 = 1'b0; sg8 = ~s; a8 = ~a; b8 = ~b;
    wait8();
  endtask

  function automatic logic [15:0] ref8(input logic s,
                                       input logic [7:0] a, b);
    int ia, ib, q, r;
    if (b == 8'h00) return {8'hFF, a};
    if (!s) return {8'(a / b), 8'(a % b)};
    ia = int'($signed(a));
    ib = int'($signed(b));
    q = ia / ib;
    r = ia % ib;
    return {q[7:0], r[7:0]};
  endfunction

  logic [15:0] m;
  logic        rs;
  logic [7:0]  ra, rb;

  initial begin
    n_chk = 0; n_fail = 0;
    rstLow = 1'b0;
    st32 = 0; sg32 = 0; a32 = '0; b32 = '0;
    st8 = 0; sg8 = 0; a8 = '0; b8 = '0;
    repeat (3) @(negedge clk);
    chk("rst q32", 64'(q32), 64'd0);
    chk("rst r32", 64'(r32), 64'd0);
    chk("rst busy32", 64'(busy32), 64'd0);
    chk("rst done32", 64'(done32), 64'd0);
    chk("rst div032", 64'(div032), 64'd0);
    chk("rst busy8", 64'(busy8), 64'd0);
    rstLow = 1'b1;
    @(negedge clk);

    op32(0, 32'd100, 32'd7, 32'd14, 32'd2, 0);
    op32(1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 0);
    op32(1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 0);
    op32(1, 32'h80000005, 32'd0, 32'hFFFFFFFF, 32'h80000005, 1);
    op32(0, 32'h80000005, 32'd0, 32'hFFFFFFFF, 32'h80000005, 1);
    op32(1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 0);
    op32(0, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 0);
    op32(0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 0);
    op32(1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14, 32'hFFFFFFFE, 0);

    // second start mid-LOOP must be dropped; old results stay visible
    @(negedge clk);
    e32.q = 64'd100; e32.r = 64'd0; e32.d0 = 0; e32.lat = 34;
    sb32.push_back(e32);
    st32 = 1; sg32 = 0; a32 = 32'd1000; b32 = 32'd10;
    @(negedge clk);
    st32 = 0;
    repeat (10) @(negedge clk);
    chk("w32 q held in loop", 64'(q32), 64'd14);
    chk("w32 r held in loop", 64'(r32), 64'hFFFFFFFE);
    st32 = 1; sg32 = 1; a32 = 32'd5; b32 = 32'd1;
    @(negedge clk);
    st32 = 0;
    wait32();

    // reset in the middle of an operation
    @(negedge clk);
    st32 = 1; sg32 = 0; a32 = 32'd100; b32 = 32'd7;
    @(negedge clk);
    st32 = 0;
    repeat (15) @(negedge clk);
    rstLow = 1'b0;
    #2;
    chk("midrst q32", 64'(q32), 64'd0);
    chk("midrst r32", 64'(r32), 64'd0);
    chk("midrst busy32", 64'(busy32), 64'd0);
    chk("midrst done32", 64'(done32), 64'd0);
    chk("midrst div032", 64'(div032), 64'd0);
    @(negedge clk);
    rstLow = 1'b1;
    @(negedge clk);
    op32(0, 32'd100, 32'd7, 32'd14, 32'd2, 0);

    // 8-bit: every op starts on the previous done cycle
    @(negedge clk);
    op8(1, 8'h80, 8'hFF, 8'h80, 8'h00, 0);
    op8(0, 8'h80, 8'hFF, 8'h00, 8'h80, 0);
    op8(1, 8'h80, 8'h00, 8'hFF, 8'h80, 1);
    op8(0, 8'hFF, 8'h00, 8'hFF, 8'hFF, 1);
    op8(1, 8'hFF, 8'hFF, 8'h01, 8'h00, 0);
    op8(1, 8'h7F, 8'h80, 8'h00, 8'h7F, 0);
    op8(0, 8'hFF, 8'h02, 8'h7F, 8'h01, 0);
    op8(1, 8'h85, 8'h03, 8'hD7, 8'h00, 0);
    op8(1, 8'hF9, 8'h02, 8'hFD, 8'hFF, 0);
    op8(0, 8'hC8, 8'h0D, 8'h0F, 8'h05, 0);
    for (int k = 0; k < 16; k++) begin
      rs = 1'($urandom_range(0, 1));
      ra = 8'($urandom);
      rb = (k % 5 == 0) ? 8'h00 : 8'($urandom);
      m = ref8(rs, ra, rb);
      op8(rs, ra, rb, m[15:8], m[7:0], rb == 8'h00);
    end

    repeat (3) @(negedge clk);
    chk("sb32 drained", 64'(sb32.size()), 64'd0);
    chk("sb8 drained", 64'(sb8.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
